rf_writeback_ctrl: RTL

// Write-port master for the register file: owns its we / write-address / write-data interface.

---
 rtl/rv_pkg.sv | 20 ++
 rtl/rf_writeback_ctrl_if.sv | 31 +++
 rtl/wb_fifo.sv | 60 ++++++
 rtl/rf_writeback_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RISC-V datapath constants and the write-back payload type.
// Used by the load-result FIFO and the register-file write-port controller.
package rv_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 1 << REG_AW;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/rf_writeback_ctrl_if.sv
// Load-response channel from the LSU into the write-back controller.
// The LSU drives the master side; the write-back controller is the slave.
interface rf_writeback_ctrl_if;
    import rv_pkg::*;

    logic              lsu_valid;
    logic              lsu_ready;
    logic [REG_AW-1:0] lsu_rd;
    logic [XLEN-1:0]   lsu_rdata;
    logic [2:0]        lsu_funct3;
    logic [1:0]        lsu_addr_lo;

    modport master (
        output lsu_valid,
        output lsu_rd,
        output lsu_rdata,
        output lsu_funct3,
        output lsu_addr_lo,
        input  lsu_ready
    );

    modport slave (
        input  lsu_valid,
        input  lsu_rd,
        input  lsu_rdata,
        input  lsu_funct3,
        input  lsu_addr_lo,
        output lsu_ready
    );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding extended load results until the write port is free.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_i,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t din,
    output wb_entry_t dout,
    output logic      full,
    output logic      empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t      mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           do_push;
    logic           do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Register-file write-port master: merges single-cycle ALU results with buffered,
// extended load responses and tracks pending loads for decode hazard detection.
module rf_writeback_ctrl
    import rv_pkg::*;
#(
    parameter int LQ_DEPTH   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              alu_valid_i,
    input  logic [REG_AW-1:0] alu_rd_i,
    input  logic [XLEN-1:0]   alu_data_i,
    rf_writeback_ctrl_if.slave lsu,
    input  logic              ld_issue_i,
    input  logic [REG_AW-1:0] ld_issue_rd_i,
    input  logic [REG_AW-1:0] q_rs1_i,
    input  logic [REG_AW-1:0] q_rs2_i,
    input  logic [REG_AW-1:0] q_rd_i,
    output logic              hazard_o,
    output logic              alu_stall_o,
    output logic              rf_we_o,
    output logic [REG_AW-1:0] rf_waddr_o,
    output logic [XLEN-1:0]   rf_wdata_o
);

    localparam int SCW = $clog2(STARVE_MAX) + 1;
    localparam logic [SCW-1:0] STARVE_LIMIT = SCW'(STARVE_MAX - 1);

    // Memory words arrive aligned; pick the addressed byte/half and widen it.
    function automatic logic [XLEN-1:0] load_extend(
        input logic [2:0]      funct3,
        input logic [1:0]      addr_lo,
        input logic [XLEN-1:0] word
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*addr_lo +: 8];
        h = word[16*addr_lo[1] +: 16];
        case (funct3)
            F3_LB:   load_extend = {{(XLEN-8){b[7]}}, b};
            F3_LH:   load_extend = {{(XLEN-16){h[15]}}, h};
            F3_LBU:  load_extend = {{(XLEN-8){1'b0}}, b};
            F3_LHU:  load_extend = {{(XLEN-16){1'b0}}, h};
            default: load_extend = word;
        endcase
    endfunction

    wb_entry_t           enq_entry;
    wb_entry_t           head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                starving;
    logic [SCW-1:0]      starve_cnt;
    logic [NUM_REGS-1:0] pending;

    assign lsu.lsu_ready = !fifo_full;
    assign push          = lsu.lsu_valid && !fifo_full;
    assign pop           = !alu_valid_i && !fifo_empty;
    assign starving      = alu_valid_i && !fifo_empty;

    always_comb begin
        enq_entry      = '0;
        enq_entry.rd   = lsu.lsu_rd;
        enq_entry.data = load_extend(lsu.lsu_funct3, lsu.lsu_addr_lo, lsu.lsu_rdata);
    end

    wb_fifo #(
        .DEPTH (LQ_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_i (rst_i),
        .push  (push),
        .pop   (pop),
        .din   (enq_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ALU has priority; a buffered load only takes the port on an ALU-free cycle.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
        end else if (alu_valid_i) begin
            rf_we_o    <= (alu_rd_i != '0);
            rf_waddr_o <= alu_rd_i;
            rf_wdata_o <= alu_data_i;
        end else if (pop) begin
            rf_we_o    <= (head.rd != '0);
            rf_waddr_o <= head.rd;
            rf_wdata_o <= head.data;
        end else begin
            rf_we_o    <= 1'b0;
        end
    end

    // Bit 0 is never set, so x0 can never raise a hazard.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            pending <= '0;
        end else begin
            if (pop && head.rd != '0) begin
                pending[head.rd] <= 1'b0;
            end
            if (ld_issue_i && ld_issue_rd_i != '0) begin
                pending[ld_issue_rd_i] <= 1'b1;
            end
        end
    end

    assign hazard_o = pending[q_rs1_i] | pending[q_rs2_i] | pending[q_rd_i];

    always_ff @(posedge clk) begin
        if (rst_i) begin
            starve_cnt  <= '0;
            alu_stall_o <= 1'b0;
        end else begin
            if (!starving) begin
                starve_cnt <= '0;
            end else if (starve_cnt < STARVE_LIMIT) begin
                starve_cnt <= starve_cnt + SCW'(1);
            end
            alu_stall_o <= starving && (starve_cnt >= STARVE_LIMIT);
        end
    end

endmodule
